load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-stage block of the RV32I core, directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Performs byte, halfword and word loads and stores over a simple req/ready data-memory handshake, with wait states.
- Stalls the pipeline while an access is outstanding.
- Returns load data to writeback, sign- or zero-extended.

Parameters:
TIMEOUT, 15, max cycles in BUS waiting for MemReady before abort; legal range 1..255
RESET_DATA, 32'h0, reset value of ReadData

Ports:
CLK  in  1  core clock, rising edge
RESETn  in  1  asynchronous active-low reset
Valid  in  1  EX stage presents a memory instruction this cycle
MemRead  in  1  load
MemWrite  in  1  store
Funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResult  in  32  effective byte address
WriteData  in  32  rs2 store data
Stall  out  1  hold upstream stages
Done  out  1  one-cycle pulse: access completed
ReadData  out  32  extended load data, valid with Done
AccessErr  out  1  one-cycle pulse: misaligned address or illegal Funct3, no bus access made
BusErr  out  1  one-cycle pulse: timeout abort
MemReq  out  1  bus request
MemWE  out  1  bus write enable
MemAddr  out  32  word-aligned address, {ALUResult[31:2],2'b00}
MemBE  out  4  byte enables
MemWData  out  32  lane-aligned store data
MemReady  in  1  bus accepts/completes access this cycle
MemRData  in  32  bus read word, valid when MemReady=1 on a read

Behaviour:
- Reset (async, RESETn=0):
  - State goes to IDLE.
  - MemReq, MemWE, Done, AccessErr and BusErr are 0.
  - MemBE, MemAddr and MemWData are 0.
  - ReadData = RESET_DATA and the timeout counter = 0.
  - If reset asserts mid-access, MemReq drops immediately and the access is abandoned with no Done.
- Request: req = Valid & (MemRead | MemWrite). If both MemRead and MemWrite are high, treat it as a store.
- Legality checks:
  - H/HU require ALUResult[0]=0.
  - W requires ALUResult[1:0]=00.
  - Stores accept only Funct3 000/001/010.
  - Loads accept 000/001/010/100/101.
  - Any other combination is illegal.
- States: IDLE, BUS, DONE.
- IDLE:
  - Legal req: register address, lanes, data and Funct3; go to BUS.
  - Illegal req: stay in IDLE; pulse AccessErr next cycle; no bus activity.
  - No req: stay in IDLE.
- BUS:
  - Drive MemReq=1 with registered MemWE, MemAddr, MemBE and MemWData, held stable until MemReady.
  - MemReady=1: capture MemRData (reads) and go to DONE.
  - Counter increments each BUS cycle without MemReady. When it reaches TIMEOUT, drop MemReq, pulse BusErr, go to IDLE, and leave ReadData unchanged.
- DONE:
  - Done=1 for one cycle. ReadData holds the extended load value for loads and is unchanged for stores.
  - Legal req in this cycle is accepted (go to BUS); otherwise go to IDLE.
  - Illegal req behaves as in IDLE: pulse AccessErr next cycle, then go to IDLE.
- Stall is combinational: (state==BUS) | (state!=BUS & legal req). It is low in the DONE cycle unless a new legal req arrives.
- Minimum latency: accept at cycle 0 → MemReq at cycle 1 → MemReady at cycle 1 → Done at cycle 2.
- Store lanes:
  - SB: MemBE = 4'b0001 << addr[1:0], MemWData = {4{WriteData[7:0]}}.
  - SH: MemBE = addr[1] ? 1100 : 0011, MemWData = {2{WriteData[15:0]}}.
  - SW: MemBE = 1111, MemWData = WriteData.
- Loads: MemBE = 1111, MemWE = 0.
  - Select the byte at addr[1:0] or the halfword at addr[1].
  - B and H sign-extend from bit 7 or 15; BU and HU zero-extend; W passes the word through.
- MemReady sampled outside BUS is ignored.
- The counter clears on entry to BUS.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, MemReady at first BUS cycle → MemReq=1, MemWE=1, MemAddr=0x100, MemBE=1111, MemWData=0xDEADBEEF; Done at cycle 2; Stall high for cycles 0-1.
- SB addr 0x203, data 0x000000A5 → MemAddr=0x200, MemBE=1000, MemWData=0xA5A5A5A5.
- LB addr 0x301 with MemRData=0x0000_80_00 (byte1=0x80) → ReadData=0xFFFFFF80; same access as LBU → ReadData=0x00000080; LHU addr 0x302, MemRData=0xBEEF0000 → ReadData=0x0000BEEF.
- LW with MemReady delayed 3 BUS cycles → MemReq and MemAddr stable for 4 cycles; Stall high throughout; Done one cycle after MemReady.
- LH addr 0x101, and SW addr 0x102 → no MemReq; AccessErr pulses once; Stall stays 0.
- TIMEOUT=15 with MemReady held 0 → MemReq drops after 15 cycles; BusErr pulses once; no Done; ReadData unchanged.
- Back-to-back: new legal LW issued during DONE → direct DONE→BUS transition with no idle cycle.
- RESETn pulsed low during BUS → MemReq=0 immediately; after release state is IDLE and no Done.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Pipeline and data-memory signals of the load/store unit.
// The master modport is the LSU side; slave is the pipeline plus memory side.
interface load_store_unit_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    logic            Valid;
    logic            MemRead;
    logic            MemWrite;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] WriteData;
    logic            Stall;
    logic            Done;
    logic [XLEN-1:0] ReadData;
    logic            AccessErr;
    logic            BusErr;
    logic            MemReq;
    logic            MemWE;
    logic [XLEN-1:0] MemAddr;
    logic [BE_W-1:0] MemBE;
    logic [XLEN-1:0] MemWData;
    logic            MemReady;
    logic [XLEN-1:0] MemRData;

    modport master (
        input  Valid, MemRead, MemWrite, Funct3, ALUResult, WriteData,
        input  MemReady, MemRData,
        output Stall, Done, ReadData, AccessErr, BusErr,
        output MemReq, MemWE, MemAddr, MemBE, MemWData
    );

    modport slave (
        output Valid, MemRead, MemWrite, Funct3, ALUResult, WriteData,
        output MemReady, MemRData,
        input  Stall, Done, ReadData, AccessErr, BusErr,
        input  MemReq, MemWE, MemAddr, MemBE, MemWData
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory stage: B/H/W loads and stores over a req/ready bus with wait
// states, timeout abort and load-data extension.
module load_store_unit #(
    parameter int unsigned TIMEOUT    = 15,
    parameter logic [31:0] RESET_DATA = 32'h0
) (
    input  logic               CLK,
    input  logic               RESETn,
    load_store_unit_if.master  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned BE_W  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    logic            req;
    logic            f3_ok;
    logic            align_ok;
    logic            legal_req;
    logic            illegal_req;
    logic [BE_W-1:0] be_c;
    logic [XLEN-1:0] wdata_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [XLEN-1:0] ext_c;

    // Request legality and store lane steering; a read+write request is a store.
    always_comb begin
        req         = bus.Valid & (bus.MemRead | bus.MemWrite);
        f3_ok       = 1'b0;
        align_ok    = 1'b0;
        be_c        = 4'b1111;
        wdata_c     = bus.WriteData;
        case (bus.Funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~bus.MemWrite;
            default:                f3_ok = 1'b0;
        endcase
        case (bus.Funct3)
            3'b000, 3'b100: align_ok = 1'b1;
            3'b001, 3'b101: align_ok = ~bus.ALUResult[0];
            3'b010:         align_ok = (bus.ALUResult[1:0] == 2'b00);
            default:        align_ok = 1'b0;
        endcase
        legal_req   = req & f3_ok & align_ok;
        illegal_req = req & ~legal_req;
        if (bus.MemWrite) begin
            case (bus.Funct3[1:0])
                2'b00: begin
                    be_c    = BE_W'(4'b0001 << bus.ALUResult[1:0]);
                    wdata_c = {4{bus.WriteData[7:0]}};
                end
                2'b01: begin
                    be_c    = bus.ALUResult[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{bus.WriteData[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = bus.WriteData;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension of the returned word.
    always_comb begin
        byte_c = bus.MemRData[7:0];
        case (off_q)
            2'd0:    byte_c = bus.MemRData[7:0];
            2'd1:    byte_c = bus.MemRData[15:8];
            2'd2:    byte_c = bus.MemRData[23:16];
            default: byte_c = bus.MemRData[31:24];
        endcase
        half_c = off_q[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];
        case (f3_q)
            3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  ext_c = {{16{half_c[15]}}, half_c};
            3'b100:  ext_c = {24'h0, byte_c};
            3'b101:  ext_c = {16'h0, half_c};
            default: ext_c = bus.MemRData;
        endcase
    end

    assign bus.Stall = (state == BUS) || ((state != BUS) && legal_req);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state         <= IDLE;
            cnt           <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            bus.MemReq    <= 1'b0;
            bus.MemWE     <= 1'b0;
            bus.MemAddr   <= '0;
            bus.MemBE     <= '0;
            bus.MemWData  <= '0;
            bus.Done      <= 1'b0;
            bus.AccessErr <= 1'b0;
            bus.BusErr    <= 1'b0;
            bus.ReadData  <= RESET_DATA;
        end else begin
            bus.Done      <= 1'b0;
            bus.AccessErr <= 1'b0;
            bus.BusErr    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (legal_req) begin
                        state        <= BUS;
                        cnt          <= '0;
                        f3_q         <= bus.Funct3;
                        off_q        <= bus.ALUResult[1:0];
                        bus.MemReq   <= 1'b1;
                        bus.MemWE    <= bus.MemWrite;
                        bus.MemAddr  <= {bus.ALUResult[31:2], 2'b00};
                        bus.MemBE    <= be_c;
                        bus.MemWData <= wdata_c;
                    end else if (illegal_req) begin
                        bus.AccessErr <= 1'b1;
                    end
                end
                BUS: begin
                    if (bus.MemReady) begin
                        state      <= DONE;
                        bus.MemReq <= 1'b0;
                        bus.Done   <= 1'b1;
                        if (!bus.MemWE) begin
                            bus.ReadData <= ext_c;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Abort: ReadData deliberately left untouched.
                        state      <= IDLE;
                        bus.MemReq <= 1'b0;
                        bus.BusErr <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
